// File: rtl/viterbi_traceback.sv
// Survivor traceback stage: gathers one frame of ACS beats, picks the
// lowest-metric state and streams its survivor path out oldest bit first.
module viterbi_traceback #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    output logic       in_ready,
    input  logic [3:0] metric_00,
    input  logic [3:0] metric_01,
    input  logic [3:0] metric_10,
    input  logic [3:0] metric_11,
    input  logic [7:0] path_00,
    input  logic [7:0] path_01,
    input  logic [7:0] path_10,
    input  logic [7:0] path_11,
    output logic       bit_out,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       last_bit,
    output logic [3:0] win_metric,
    output logic [1:0] win_state,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        COLLECT,
        SELECT,
        OUTPUT
    } state_t;

    localparam logic [3:0]  LAST_IDX = 4'(FRAME_LEN - 1);
    localparam int unsigned ALIGN    = 8 - FRAME_LEN;

    state_t          state;
    logic [3:0]      beat_cnt;
    logic [3:0]      bit_cnt;
    logic [3:0][3:0] metric_q;
    logic [3:0][7:0] path_q;
    logic [7:0]      shift_q;

    logic [1:0]      best_idx;
    logic [3:0]      best_metric;
    logic [7:0]      best_path;
    logic [7:0]      aligned;

    // Strict less-than keeps the earlier (lower) index on ties.
    always_comb begin
        best_idx    = 2'd0;
        best_metric = metric_q[0];
        for (int unsigned i = 1; i < 4; i++) begin
            if (metric_q[i] < best_metric) begin
                best_idx    = 2'(i);
                best_metric = metric_q[i];
            end
        end
        best_path = path_q[best_idx];
        aligned   = best_path << ALIGN;
    end

    // The oldest frame bit is moved to bit 7 so emission is always a left shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= COLLECT;
            beat_cnt   <= '0;
            bit_cnt    <= '0;
            metric_q   <= '0;
            path_q     <= '0;
            shift_q    <= '0;
            in_ready   <= 1'b1;
            bit_valid  <= 1'b0;
            bit_out    <= 1'b0;
            last_bit   <= 1'b0;
            win_metric <= '0;
            win_state  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                COLLECT: begin
                    if (valid_in) begin
                        metric_q <= {metric_11, metric_10, metric_01, metric_00};
                        path_q   <= {path_11, path_10, path_01, path_00};
                        if (beat_cnt == LAST_IDX) begin
                            beat_cnt <= '0;
                            in_ready <= 1'b0;
                            state    <= SELECT;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end
                SELECT: begin
                    win_state  <= best_idx;
                    win_metric <= best_metric;
                    bit_out    <= aligned[7];
                    shift_q    <= aligned << 1;
                    bit_cnt    <= '0;
                    last_bit   <= (LAST_IDX == 4'd0);
                    bit_valid  <= 1'b1;
                    state      <= OUTPUT;
                end
                OUTPUT: begin
                    if (bit_ready) begin
                        if (bit_cnt == LAST_IDX) begin
                            bit_valid  <= 1'b0;
                            bit_out    <= 1'b0;
                            last_bit   <= 1'b0;
                            in_ready   <= 1'b1;
                            frame_done <= 1'b1;
                            state      <= COLLECT;
                        end else begin
                            bit_out  <= shift_q[7];
                            shift_q  <= shift_q << 1;
                            bit_cnt  <= bit_cnt + 4'd1;
                            last_bit <= (4'(bit_cnt + 4'd1) == LAST_IDX);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Scoreboard bench: three traceback instances (FRAME_LEN 8, 4, 1) exercised
// one at a time with directed frames; a negedge monitor checks every output.
module tb_viterbi_traceback;

    localparam logic [47:0] FILLER = 48'h0123_5A5A_5A5A;

    typedef struct {
        int         inst;
        logic       b;
        logic       last;
        logic [3:0] wm;
        logic [1:0] ws;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_ready = 1'b1;
    logic [47:0] beat = '0;
    logic        vin8 = 1'b0, vin4 = 1'b0, vin1 = 1'b0;

    logic       ir8, bo8, bv8, lb8, fd8;
    logic       ir4, bo4, bv4, lb4, fd4;
    logic       ir1, bo1, bv1, lb1, fd1;
    logic [3:0] wm8, wm4, wm1;
    logic [1:0] ws8, ws4, ws1;

    exp_t exp_q[$];
    bit   pend[3];
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    viterbi_traceback #(.FRAME_LEN(8)) u8 (
        .clk(clk), .rst(rst), .valid_in(vin8), .in_ready(ir8),
        .metric_00(beat[47:44]), .metric_01(beat[43:40]), .metric_10(beat[39:36]), .metric_11(beat[35:32]),
        .path_00(beat[31:24]), .path_01(beat[23:16]), .path_10(beat[15:8]), .path_11(beat[7:0]),
        .bit_out(bo8), .bit_valid(bv8), .bit_ready(bit_ready), .last_bit(lb8),
        .win_metric(wm8), .win_state(ws8), .frame_done(fd8)
    );

    viterbi_traceback #(.FRAME_LEN(4)) u4 (
        .clk(clk), .rst(rst), .valid_in(vin4), .in_ready(ir4),
        .metric_00(beat[47:44]), .metric_01(beat[43:40]), .metric_10(beat[39:36]), .metric_11(beat[35:32]),
        .path_00(beat[31:24]), .path_01(beat[23:16]), .path_10(beat[15:8]), .path_11(beat[7:0]),
        .bit_out(bo4), .bit_valid(bv4), .bit_ready(bit_ready), .last_bit(lb4),
        .win_metric(wm4), .win_state(ws4), .frame_done(fd4)
    );

    viterbi_traceback #(.FRAME_LEN(1)) u1 (
        .clk(clk), .rst(rst), .valid_in(vin1), .in_ready(ir1),
        .metric_00(beat[47:44]), .metric_01(beat[43:40]), .metric_10(beat[39:36]), .metric_11(beat[35:32]),
        .path_00(beat[31:24]), .path_01(beat[23:16]), .path_10(beat[15:8]), .path_11(beat[7:0]),
        .bit_out(bo1), .bit_valid(bv1), .bit_ready(bit_ready), .last_bit(lb1),
        .win_metric(wm1), .win_state(ws1), .frame_done(fd1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic set_vin(input int id, input logic v);
        case (id)
            0: vin8 = v;
            1: vin4 = v;
            default: vin1 = v;
        endcase
    endtask

    function automatic logic get_bv(input int id);
        return (id == 0) ? bv8 : (id == 1) ? bv4 : bv1;
    endfunction

    function automatic logic get_ir(input int id);
        return (id == 0) ? ir8 : (id == 1) ? ir4 : ir1;
    endfunction

    task automatic mon(input int id, input logic bv, input logic bo, input logic lb, input logic fd,
                       input logic ir, input logic [3:0] wm, input logic [1:0] ws);
        if (!rst) begin
            pend[id] = 1'b0;
            return;
        end
        chk("frame_done", fd, pend[id]);
        if (pend[id]) begin
            chk("done_in_ready", ir, 1'b1);
            chk("done_bit_valid", bv, 1'b0);
        end
        pend[id] = 1'b0;
        if (bv) begin
            if (exp_q.size() == 0 || exp_q[0].inst != id) begin
                chk("unexpected_bit", 32'(id), 32'hFF);
            end else begin
                chk("bit_out", bo, exp_q[0].b);
                chk("last_bit", lb, exp_q[0].last);
                chk("win_metric", wm, exp_q[0].wm);
                chk("win_state", ws, exp_q[0].ws);
                if (bit_ready) begin
                    pend[id] = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) mon(0, bv8, bo8, lb8, fd8, ir8, wm8, ws8);
    always @(negedge clk) mon(1, bv4, bo4, lb4, fd4, ir4, wm4, ws4);
    always @(negedge clk) mon(2, bv1, bo1, lb1, fd1, ir1, wm1, ws1);

    // ebits lists the expected bits in emission order starting at bit 7.
    task automatic run_frame(input int id, input int fl, input logic [47:0] lastb,
                             input logic [7:0] ebits, input logic [1:0] ews, input logic [3:0] ewm,
                             input bit bp, input bit ign, input int rst_after);
        int   cyc;
        int   n;
        exp_t e;
        for (int k = 0; k < fl; k++) begin
            e.inst = id;
            e.b    = ebits[7-k];
            e.last = (k == fl - 1);
            e.wm   = ewm;
            e.ws   = ews;
            exp_q.push_back(e);
        end
        bit_ready = bp ? 1'b0 : 1'b1;
        for (int i = 0; i < fl; i++) begin
            @(posedge clk); #1;
            set_vin(id, 1'b1);
            beat = (i == fl - 1) ? lastb : FILLER;
        end
        @(posedge clk); #1;
        if (ign) beat = {16'h0000, 32'hC3C3_C3C3};
        else set_vin(id, 1'b0);
        chk("select_in_ready", get_ir(id), 1'b0);
        chk("select_bit_valid", get_bv(id), 1'b0);
        @(posedge clk); #1;
        chk("latency_bit_valid", get_bv(id), 1'b1);
        cyc = 0;
        n   = 0;
        while (get_bv(id) && cyc < 64) begin
            if (rst_after != 0 && n == rst_after) break;
            if (bit_ready) n++;
            cyc++;
            @(posedge clk); #1;
            if (bp) bit_ready = ~bit_ready;
            if (ign) beat = {16'h0000, {4{8'(cyc * 37)}}};
        end
        set_vin(id, 1'b0);
        if (rst_after != 0) begin
            #1;
            exp_q.delete();
            rst = 1'b0;
            #1;
            chk("rst_bit_valid", get_bv(id), 1'b0);
            chk("rst_in_ready", get_ir(id), 1'b1);
            @(negedge clk); #2;
            rst = 1'b1;
        end else begin
            chk("drain_cycles", 32'(cyc), 32'(bp ? 2 * fl : fl));
        end
        bit_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", ir8, 1'b1);
        chk("reset_bit_valid", bv8, 1'b0);
        chk("reset_bit_out", bo8, 1'b0);
        chk("reset_last_bit", lb8, 1'b0);
        chk("reset_frame_done", fd8, 1'b0);
        chk("reset_win_metric", wm8, 4'd0);
        chk("reset_win_state", ws8, 2'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        run_frame(0, 8, 48'h5272_FFCC_0033, 8'b11001100, 2'd1, 4'd2, 1'b0, 1'b0, 0);
        run_frame(1, 4, 48'h0333_A6FF_FFFF, 8'b01100000, 2'd0, 4'd0, 1'b0, 1'b0, 0);
        run_frame(0, 8, 48'h9999_9A00_0000, 8'b10011010, 2'd0, 4'd9, 1'b1, 1'b0, 0);
        run_frame(0, 8, 48'hFE1F_0000_7100, 8'b01110001, 2'd2, 4'd1, 1'b0, 1'b1, 0);
        run_frame(0, 8, 48'h8763_0000_000F, 8'b00001111, 2'd3, 4'd3, 1'b0, 1'b0, 0);
        run_frame(0, 8, 48'h1111_F000_0000, 8'b11110000, 2'd0, 4'd1, 1'b0, 1'b0, 3);
        run_frame(0, 8, 48'h4440_0000_005A, 8'b01011010, 2'd3, 4'd0, 1'b0, 1'b0, 0);
        run_frame(2, 1, 48'h3210_0000_0001, 8'b10000000, 2'd3, 4'd0, 1'b0, 1'b0, 0);
        run_frame(2, 1, 48'h2255_FEFF_0000, 8'b00000000, 2'd0, 4'd2, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_traceback.md
VITERBI_TRACEBACK -- requirements
Module: viterbi_traceback

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 Parameter FRAME_LEN, default 8: the number of ACS steps per frame and the number of decoded bits emitted per frame; the legal range SHALL be 1..8.
REQ-003 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 SHALL immediately force the reset state.
REQ-005 valid_in  input  1  the ACS outputs are valid this cycle.
REQ-006 in_ready  output  1  the block accepts ACS beats this cycle.
REQ-007 metric_00, metric_01, metric_10, metric_11  input  4 each  path metrics of states 00, 01, 10 and 11 from the ACS.
REQ-008 path_00, path_01, path_10, path_11  input  8 each  survivor histories from the ACS; the newest bit is at the LSB.
REQ-009 bit_out  output  1  the decoded bit.
REQ-010 bit_valid  output  1  bit_out is valid.
REQ-011 bit_ready  input  1  the downstream consumer accepts bit_out.
REQ-012 last_bit  output  1  high with the final bit of the frame.
REQ-013 win_metric  output  4  metric of the winning state; held stable while bit_valid is high.
REQ-014 win_state  output  2  index of the winning state (00..11).
REQ-015 frame_done  output  1  one-cycle pulse after the last bit is accepted.

Function
REQ-016 The state machine SHALL have exactly three states: COLLECT, SELECT and OUTPUT; the reset state SHALL be COLLECT.
REQ-017 COLLECT: in_ready=1 and bit_valid=0; each cycle with valid_in=1 SHALL be one beat that increments beat_cnt (width 4).
REQ-018 Every beat SHALL latch all four metrics and all four paths into internal registers.
REQ-019 The beat that brings beat_cnt to FRAME_LEN SHALL clear beat_cnt and move the FSM to SELECT on the next edge.
REQ-020 SELECT SHALL last exactly one cycle with in_ready=0.
REQ-021 SELECT SHALL find the minimum latched metric using unsigned comparison; on a tie the lowest state index SHALL win (00 > 01 > 10 > 11 in priority).
REQ-022 SELECT SHALL load win_state, win_metric and a shift register holding bits [FRAME_LEN-1:0] of the winning path, then move to OUTPUT.
REQ-023 OUTPUT: bit_valid=1 and in_ready=0; bit_out SHALL present the oldest bit first, so the k-th bit (k=0..FRAME_LEN-1) is winning path bit [FRAME_LEN-1-k].
REQ-024 A bit SHALL be transferred only in a cycle where bit_valid=1 and bit_ready=1; with bit_ready=0, bit_out, last_bit, win_metric and win_state SHALL hold.
REQ-025 last_bit SHALL be 1 only while the bit with k=FRAME_LEN-1 is presented.
REQ-026 The transfer of that last bit SHALL pulse frame_done=1 for the following cycle and return the FSM to COLLECT in that same cycle, with in_ready=1.
REQ-027 valid_in during SELECT or OUTPUT SHALL be ignored: no latch and no count.
REQ-028 Latency from the final input beat to bit_valid rising SHALL be 2 cycles.
REQ-029 With bit_ready held at 1, the frame SHALL drain in FRAME_LEN cycles.
REQ-030 FRAME_LEN=1: a single beat SHALL produce a single bit with last_bit=1.

Reset
REQ-031 rst=0 SHALL asynchronously force FSM=COLLECT and beat_cnt=0.
REQ-032 rst=0 SHALL asynchronously force in_ready=1 once the FSM is in COLLECT, and bit_valid=0, bit_out=0, last_bit=0, frame_done=0, win_metric=0 and win_state=0.
REQ-033 rst=0 SHALL clear the shift register and all latched metrics and paths to 0.
REQ-034 A reset asserted mid-frame, in any state, SHALL discard the partial frame; after release, counting SHALL restart from beat 0.

Verification
REQ-035 Scenario (FRAME_LEN=8, bit_ready=1): 8 beats, last beat metrics 5,2,7,2 and path_01=8'b11001100 -> win_state=01 (tie with 11, lower index wins), win_metric=2, bits 1,1,0,0,1,1,0,0, last_bit on the 8th bit, frame_done one cycle later.
REQ-036 Scenario (FRAME_LEN=4): last beat metrics 0,3,3,3 and path_00=8'b10100110 -> bits 0,1,1,0.
REQ-037 Scenario (back-pressure): bit_ready toggled 0/1 every cycle during OUTPUT -> no bit is lost or duplicated, outputs hold while bit_ready=0, and the frame takes 16 cycles for FRAME_LEN=8.
REQ-038 Scenario (ignored input): valid_in=1 continuously through SELECT and OUTPUT with changing data -> the emitted bits match the frame-final beat only, and the next frame needs a full FRAME_LEN beats.
REQ-039 Scenario (reset mid-output): rst=0 after the 3rd bit is accepted -> bit_valid=0 asynchronously and in_ready=1; after release, 8 new beats produce a complete, correct frame.
REQ-040 Scenario (all metrics equal at 9): -> win_state=00 and win_metric=9.
